// File: rtl/LOAD_STORE_FNS.sv
// LOAD_STORE_FNS: RISC-V load/store funct3 encodings for access size and sign.
package LOAD_STORE_FNS;
   typedef enum logic [2:0] {
      BYTE   = 3'b000,
      HALF   = 3'b001,
      WORD   = 3'b010,
      BYTE_U = 3'b100,
      HALF_U = 3'b101
   } funct3_t;
endpackage

// File: rtl/common.sv
// common: system-wide constants shared by the core's memory-mapped blocks.
//   OUTPORT_ADDR - byte address of the board-level output register
//   WIDTH        - default data/address width
package common;
   localparam logic [31:0] OUTPORT_ADDR = 32'h0000_FFFC;
   localparam int WIDTH = 32;
endpackage

// File: rtl/memory_ram.sv
// memory_ram: DEPTH x WIDTH synchronous RAM with byte enables and write-first registered read.
// Ports: clk, rst (async active-low, clears only the read register),
//        flash_en/flash_idx/flash_data (full-word preload port, has priority),
//        wr_be/idx/wr_data (byte-enabled store port), rd_data (registered word at idx).
module memory_ram #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 256,
   localparam int AW    = $clog2(DEPTH),
   localparam int NB    = WIDTH / 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flash_en,
   input  logic [AW-1:0]    flash_idx,
   input  logic [WIDTH-1:0] flash_data,
   input  logic [NB-1:0]    wr_be,
   input  logic [AW-1:0]    idx,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [NB-1:0]    be;
   logic [AW-1:0]    w_idx;
   logic [WIDTH-1:0] w_word, merged;
   // A single physical write port: flash steals it whole, dropping any store.
   always_comb begin
      be     = flash_en ? '1 : wr_be;
      w_idx  = flash_en ? flash_idx : idx;
      w_word = flash_en ? flash_data : wr_data;
      merged = mem[w_idx];
      for (int b = 0; b < NB; b++) if (be[b]) merged[8*b +: 8] = w_word[8*b +: 8];
   end
   always_ff @(posedge clk)
      if (|be) mem[w_idx] <= merged;
   // Write-first: a read of the word being written returns the merged result.
   always_ff @(posedge clk or negedge rst)
      if (!rst) rd_data <= '0;
      else      rd_data <= (|be && w_idx == idx) ? merged : mem[idx];
endmodule

// File: rtl/memory.sv
// memory: RISC-V data memory with sized loads/stores, memory-mapped outport and flash preload.
// Ports: clk, rst (async active-low), addr/wren/wr_data/funct3 (load/store access),
//        rd_data (registered load result), outport (output register at OUTPORT_ADDR),
//        flash_addr/flash_data/flash_en (full-word preload, works during reset).
// Option: MEMORY_SUBWORD_EN enables byte/half stores and sized, extended loads;
//         without it every access is a full aligned word and funct3 is ignored.
module memory
   import LOAD_STORE_FNS::*;
#(
   parameter int WIDTH = common::WIDTH,
   parameter int DEPTH = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] addr,
   input  logic             wren,
   input  logic [WIDTH-1:0] wr_data,
   input  funct3_t          funct3,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] outport,
   input  logic [WIDTH-1:0] flash_addr,
   input  logic [WIDTH-1:0] flash_data,
   input  logic             flash_en
);
   localparam int AW = $clog2(DEPTH);
   logic             is_out, out_q, unused_ok;
   logic [3:0]       wr_be;
   logic [WIDTH-1:0] wr_word, raw;
   assign is_out = addr == common::OUTPORT_ADDR;
`ifdef MEMORY_SUBWORD_EN
   logic       is_b, is_h;
   logic [1:0] lo_q;
   funct3_t    f3_q;
   logic [7:0] b_sel;
   logic [15:0] h_sel;
   assign is_b    = funct3 == BYTE || funct3 == BYTE_U;
   assign is_h    = funct3 == HALF || funct3 == HALF_U;
   // Store data is replicated across lanes so the byte enables alone pick the target.
   assign wr_be   = !(wren && !is_out) ? 4'h0 :
                    is_b ? 4'b0001 << addr[1:0] :
                    is_h ? (addr[1] ? 4'b1100 : 4'b0011) : 4'hF;
   assign wr_word = is_b ? {4{wr_data[7:0]}} : is_h ? {2{wr_data[15:0]}} : wr_data;
   assign b_sel   = 8'(raw >> {lo_q, 3'b000});
   assign h_sel   = lo_q[1] ? raw[31:16] : raw[15:0];
   assign rd_data = out_q ? '0 :
                    f3_q == BYTE   ? {{24{b_sel[7]}}, b_sel} :
                    f3_q == BYTE_U ? {24'h0, b_sel} :
                    f3_q == HALF   ? {{16{h_sel[15]}}, h_sel} :
                    f3_q == HALF_U ? {16'h0, h_sel} : raw;
   assign unused_ok = ^{flash_addr[WIDTH-1:AW+2], flash_addr[1:0]};
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         lo_q <= 2'b00;
         f3_q <= WORD;
      end else begin
         lo_q <= addr[1:0];
         f3_q <= funct3;
      end
`else
   assign wr_be     = (wren && !is_out) ? 4'hF : 4'h0;
   assign wr_word   = wr_data;
   assign rd_data   = out_q ? '0 : raw;
   assign unused_ok = ^{flash_addr[WIDTH-1:AW+2], flash_addr[1:0], funct3};
`endif
   // out_q remembers that the registered read targeted the outport, which reads as 0.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         out_q   <= 1'b0;
         outport <= '0;
      end else begin
         out_q <= is_out;
         if (wren && is_out) outport <= wr_data;
      end
   memory_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
      .clk        (clk),
      .rst        (rst),
      .flash_en   (flash_en),
      .flash_idx  (flash_addr[AW+1:2]),
      .flash_data (flash_data),
      .wr_be      (wr_be),
      .idx        (addr[AW+1:2]),
      .wr_data    (wr_word),
      .rd_data    (raw)
   );
endmodule

// File: tb/tb_memory.sv
// tb_memory: directed and randomized checks of memory against a byte-array reference model.
module tb_memory;
   import LOAD_STORE_FNS::*;
   localparam int DEPTH = 256;
   localparam logic [31:0] OUT_A = 32'h0000_FFFC;
`ifdef MEMORY_SUBWORD_EN
   localparam bit SUB = 1'b1;
`else
   localparam bit SUB = 1'b0;
`endif
   logic        clk = 1'b0, rst = 1'b0, wren = 1'b0, flash_en = 1'b0;
   logic [31:0] addr = '0, wr_data = '0, flash_addr = '0, flash_data = '0;
   funct3_t     funct3 = WORD;
   logic [31:0] rd_data, outport;
   int          n_assert = 0, n_fail = 0;
   logic [7:0]  mb [DEPTH*4];
   logic [31:0] m_out = '0;

   memory dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .wren       (wren),
      .wr_data    (wr_data),
      .funct3     (funct3),
      .rd_data    (rd_data),
      .outport    (outport),
      .flash_addr (flash_addr),
      .flash_data (flash_data),
      .flash_en   (flash_en)
   );

   always #5 clk = ~clk;

   function automatic int base(input logic [31:0] a);
      return int'((a / 4) % DEPTH) * 4;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f3);
      int i;
      logic [31:0] w;
      i = base(a);
      w = {mb[i+3], mb[i+2], mb[i+1], mb[i]};
      if (a == OUT_A) return '0;
      if (SUB) begin
         logic signed [7:0]  b;
         logic signed [15:0] h;
         int o;
         b = mb[i + int'(a % 4)];
         o = i + int'(a % 4) / 2 * 2;
         h = {mb[o+1], mb[o]};
         if (f3 == 3'b000) return 32'(b);
         if (f3 == 3'b100) return 32'(mb[i + int'(a % 4)]);
         if (f3 == 3'b001) return 32'(h);
         if (f3 == 3'b101) return {16'h0, mb[o+1], mb[o]};
      end
      return w;
   endfunction

   task automatic m_store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
      int i, o;
      i = base(a);
      o = i + int'(a % 4) / 2 * 2;
      if (SUB && (f3 == 3'b000 || f3 == 3'b100)) mb[i + int'(a % 4)] = wd[7:0];
      else if (SUB && (f3 == 3'b001 || f3 == 3'b101)) begin
         mb[o]   = wd[7:0];
         mb[o+1] = wd[15:8];
      end else for (int k = 0; k < 4; k++) mb[i + k] = wd[8*k +: 8];
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, update the model at the edge, check rd_data/outport after it.
   task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, input logic fe, input logic [31:0] fa,
                       input logic [31:0] fd);
      logic [31:0] e_rd;
      wren = we; addr = a; wr_data = wd; funct3 = funct3_t'(f3);
      flash_en = fe; flash_addr = fa; flash_data = fd;
      @(posedge clk);
      if (rst && we && a == OUT_A) m_out = wd;
      if (we && a != OUT_A && !fe) m_store(a, wd, f3);
      if (fe) for (int k = 0; k < 4; k++) mb[base(fa) + k] = fd[8*k +: 8];
      if (!rst) m_out = '0;
      e_rd = rst ? m_load(a, f3) : '0;
      #1;
      chk("rd_data", rd_data, e_rd);
      chk("outport", outport, m_out);
      wren = 1'b0;
      flash_en = 1'b0;
   endtask

   initial begin
      logic [31:0] a, wd;
      logic [2:0]  f3;
      logic        we, fe;
      int          r;
      for (int i = 0; i < DEPTH; i++)
         step(1'b0, 32'h0, 32'h0, 3'b010, 1'b1, 32'(i * 4), i == 255 ? 32'h0BAD_F00D : $urandom());
      chk("reset_rd", rd_data, 32'h0);
      chk("reset_out", outport, 32'h0);
      step(1'b0, 32'h0, 32'h0, 3'b010, 1'b1, 32'd0, 32'd12345);
      step(1'b0, 32'h0, 32'h0, 3'b010, 1'b1, 32'd4, 32'd678910);
      step(1'b0, 32'h0, 32'h0, 3'b010, 1'b1, 32'd12, 32'hFFFF_FFFF);
      rst = 1'b1;
      step(1'b0, 32'd0, 32'h0, 3'b010, 1'b0, 32'h0, 32'h0);
      chk("lw0", rd_data, 32'd12345);
      step(1'b0, 32'd4, 32'h0, 3'b010, 1'b0, 32'h0, 32'h0);
      chk("lw4", rd_data, 32'd678910);
      step(1'b0, 32'd12, 32'h0, 3'b010, 1'b0, 32'h0, 32'h0);
      chk("lw12_init", rd_data, 32'hFFFF_FFFF);
      step(1'b1, 32'd8, 32'd101010, 3'b010, 1'b0, 32'h0, 32'h0);
      chk("sw8_write_first", rd_data, 32'd101010);
      step(1'b0, 32'd8, 32'h0, 3'b010, 1'b0, 32'h0, 32'h0);
      chk("lw8", rd_data, 32'd101010);
      step(1'b1, OUT_A, 32'hDEAD_BEEF, 3'b010, 1'b0, 32'h0, 32'h0);
      chk("outport_set", outport, 32'hDEAD_BEEF);
      chk("outport_rd", rd_data, 32'h0);
      step(1'b0, OUT_A, 32'h0, 3'b010, 1'b0, 32'h0, 32'h0);
      chk("lw_outport", rd_data, 32'h0);
      step(1'b0, 32'h3FC, 32'h0, 3'b010, 1'b0, 32'h0, 32'h0);
      chk("alias_word", rd_data, 32'h0BAD_F00D);
      step(1'b1, 32'd13, 32'h12, 3'b000, 1'b0, 32'h0, 32'h0);
      step(1'b0, 32'd12, 32'h0, 3'b010, 1'b0, 32'h0, 32'h0);
      chk("lw12_after_sb", rd_data, SUB ? 32'hFFFF_12FF : 32'h0000_0012);
      step(1'b0, 32'd13, 32'h0, 3'b000, 1'b0, 32'h0, 32'h0);
      chk("lb13", rd_data, 32'h0000_0012);
      step(1'b0, 32'd12, 32'h0, 3'b100, 1'b0, 32'h0, 32'h0);
      chk("lbu12", rd_data, SUB ? 32'h0000_00FF : 32'h0000_0012);
      step(1'b0, 32'd12, 32'h0, 3'b000, 1'b0, 32'h0, 32'h0);
      chk("lb12", rd_data, SUB ? 32'hFFFF_FFFF : 32'h0000_0012);
      step(1'b1, 32'd6, 32'h8001, 3'b001, 1'b0, 32'h0, 32'h0);
      step(1'b0, 32'd6, 32'h0, 3'b001, 1'b0, 32'h0, 32'h0);
      chk("lh6", rd_data, SUB ? 32'hFFFF_8001 : 32'h0000_8001);
      step(1'b0, 32'd6, 32'h0, 3'b101, 1'b0, 32'h0, 32'h0);
      chk("lhu6", rd_data, 32'h0000_8001);
      step(1'b0, 32'd12, 32'h0, 3'b011, 1'b0, 32'h0, 32'h0);
      chk("undef_f3", rd_data, SUB ? 32'hFFFF_12FF : 32'h0000_0012);
      step(1'b1, 32'd16, 32'hAAAA_AAAA, 3'b010, 1'b1, 32'd16, 32'h5555_5555);
      chk("flash_priority", rd_data, 32'h5555_5555);
      step(1'b0, 32'd16, 32'h0, 3'b010, 1'b0, 32'h0, 32'h0);
      chk("flash_priority_rd", rd_data, 32'h5555_5555);
      #2 rst = 1'b0;
      m_out = '0;
      #1;
      chk("async_rd", rd_data, 32'h0);
      chk("async_out", outport, 32'h0);
      step(1'b0, 32'd0, 32'h0, 3'b010, 1'b1, 32'd20, 32'hCAFE_F00D);
      rst = 1'b1;
      step(1'b0, 32'd0, 32'h0, 3'b010, 1'b0, 32'h0, 32'h0);
      chk("post_reset_lw0", rd_data, 32'd12345);
      step(1'b0, 32'd20, 32'h0, 3'b010, 1'b0, 32'h0, 32'h0);
      chk("flash_in_reset", rd_data, 32'hCAFE_F00D);
      for (int n = 0; n < 400; n++) begin
         r  = int'($urandom_range(0, 9));
         a  = r == 0 ? OUT_A : r == 1 ? $urandom() : 32'($urandom_range(0, 1023));
         wd = $urandom();
         f3 = 3'($urandom_range(0, 7));
         we = $urandom_range(0, 2) == 0;
         fe = !we && $urandom_range(0, 5) == 0;
         step(we, a, wd, f3, fe, 32'($urandom_range(0, 1023)), $urandom());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
